// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's memory-side and decoder-side signals.
// master = fetch unit, slave = instruction memory / decode / datapath side.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic        decode_ready;
    logic [31:0] pc_plus4;
    logic        branch_taken;
    logic        jump;
    logic [31:0] retired_count;

    modport master (
        output imem_req, imem_addr,
        input  imem_ready, imem_rdata,
        output instr, opcode, instr_valid, pc_plus4, retired_count,
        input  decode_ready, branch_taken, jump
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ready, imem_rdata,
        input  instr, opcode, instr_valid, pc_plus4, retired_count,
        output decode_ready, branch_taken, jump
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one word at a time and hands it
// to the decoder, then picks the next PC from the branch/jump outcome on consume.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic          clk,
    input logic          reset,
    fetch_unit_if.master bus
);
    typedef enum logic {
        FETCH = 1'b0,
        VALID = 1'b1
    } state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] instr_reg, instr_next;
    logic [31:0] count_reg, count_next;
    logic [31:0] pc_plus4;
    logic [31:0] branch_offset;
    logic [31:0] target_pc;

    assign pc_plus4      = pc_reg + 32'd4;
    assign branch_offset = {{14{instr_reg[15]}}, instr_reg[15:0], 2'b00};

    // Jump has priority over a taken branch.
    always_comb begin
        if (bus.jump) begin
            target_pc = {pc_plus4[31:28], instr_reg[25:0], 2'b00};
        end else if (bus.branch_taken) begin
            target_pc = pc_plus4 + branch_offset;
        end else begin
            target_pc = pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= FETCH;
            pc_reg    <= RESET_PC_ALIGNED;
            instr_reg <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            instr_reg <= instr_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        instr_next = instr_reg;
        count_next = count_reg;
        case (state_reg)
            FETCH: begin
                if (bus.imem_ready) begin
                    instr_next = bus.imem_rdata;
                    state_next = VALID;
                end
            end
            VALID: begin
                if (bus.decode_ready) begin
                    pc_next    = target_pc;
                    count_next = count_reg + 32'd1;
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    // Handshake outputs are held low while reset is asserted, whatever the state.
    always_comb begin
        bus.imem_req    = 1'b0;
        bus.instr_valid = 1'b0;
        if (!reset) begin
            case (state_reg)
                FETCH:   bus.imem_req    = 1'b1;
                VALID:   bus.instr_valid = 1'b1;
                default: bus.imem_req    = 1'b0;
            endcase
        end
    end

    assign bus.imem_addr     = pc_reg;
    assign bus.instr         = instr_reg;
    assign bus.opcode        = instr_reg[31:26];
    assign bus.pc_plus4      = pc_plus4;
    assign bus.retired_count = count_reg;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a transaction-level model is compared every cycle,
// and hand-computed addresses/counts pin the model at key points.
module tb_fetch_unit;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: either waiting for a word or holding one, plus the PC and retire count.
    logic        m_started;
    logic        m_held;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_count;

    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ins,
                                               input logic j, input logic b);
        logic [31:0] seq;
        int          imm;
        seq = pc + 32'd4;
        if (j) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
        imm = int'($signed(ins[15:0]));
        if (b) return seq + 32'(imm * 4);
        return seq;
    endfunction

    initial m_started = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_started = 1'b1;
            m_held    = 1'b0;
            m_pc      = 32'h0000_0000;
            m_instr   = 32'h0;
            m_count   = 32'h0;
        end else if (m_started) begin
            if (!m_held) begin
                if (bus.imem_ready) begin
                    m_instr = bus.imem_rdata;
                    m_held  = 1'b1;
                end
            end else if (bus.decode_ready) begin
                m_pc    = model_next(m_pc, m_instr, bus.jump, bus.branch_taken);
                m_count = m_count + 32'd1;
                m_held  = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic compare_cycle();
        logic exp_req;
        logic exp_valid;
        if (!m_started) return;
        exp_req   = !reset && !m_held;
        exp_valid = !reset && m_held;
        check("model imem_req", 32'(bus.imem_req), 32'(exp_req));
        check("model instr_valid", 32'(bus.instr_valid), 32'(exp_valid));
        check("model imem_addr", bus.imem_addr, m_pc);
        check("model retired_count", bus.retired_count, m_count);
        if (exp_valid) begin
            check("model instr", bus.instr, m_instr);
            check("model opcode", 32'(bus.opcode), 32'(m_instr[31:26]));
            check("model pc_plus4", bus.pc_plus4, m_pc + 32'd4);
        end
    endtask

    // One clock: let the edge happen, then compare at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        compare_cycle();
    endtask

    // Fetch one word, hold it one cycle with branch/jump asserted but no consume,
    // then consume it with the given resolution.
    task automatic fetch_consume(input logic [31:0] word, input logic br, input logic jp);
        logic [31:0] held_addr;
        bus.imem_ready   = 1'b1;
        bus.imem_rdata   = word;
        bus.decode_ready = 1'b0;
        bus.branch_taken = 1'b1;
        bus.jump         = 1'b1;
        tick();
        held_addr        = bus.imem_addr;
        bus.imem_ready   = 1'b0;
        tick();
        check("ignored resolution addr", bus.imem_addr, held_addr);
        bus.branch_taken = br;
        bus.jump         = jp;
        bus.decode_ready = 1'b1;
        tick();
        bus.decode_ready = 1'b0;
        bus.branch_taken = 1'b0;
        bus.jump         = 1'b0;
        $display("consume instr=%h branch=%0b jump=%0b next_addr=%h retired=%0d",
                 word, br, jp, bus.imem_addr, bus.retired_count);
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        reset            = 1'b1;
        bus.imem_ready   = 1'b1;
        bus.imem_rdata   = 32'hDEAD_BEEF;
        bus.decode_ready = 1'b0;
        bus.branch_taken = 1'b0;
        bus.jump         = 1'b0;

        // Reset with a live memory response
        for (int i = 0; i < 2; i++) begin
            tick();
            check("reset imem_req", 32'(bus.imem_req), 32'h0);
            check("reset instr_valid", 32'(bus.instr_valid), 32'h0);
        end
        reset = 1'b0;
        #1;
        check("post-reset imem_req", 32'(bus.imem_req), 32'h1);
        check("post-reset imem_addr", bus.imem_addr, 32'h0);

        // Sequential fetch
        bus.imem_rdata   = 32'h2008_0001;
        bus.decode_ready = 1'b1;
        tick();
        check("seq opcode", 32'(bus.opcode), 32'h08);
        check("seq instr_valid", 32'(bus.instr_valid), 32'h1);
        tick();
        check("seq addr1", bus.imem_addr, 32'h4);
        tick();
        tick();
        check("seq addr2", bus.imem_addr, 32'h8);
        check("seq count2", bus.retired_count, 32'd2);
        $display("sequential: two consumes, addr=%h", bus.imem_addr);

        // Memory stall at 0x8
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall imem_req", 32'(bus.imem_req), 32'h1);
            check("stall imem_addr", bus.imem_addr, 32'h8);
            check("stall instr_valid", 32'(bus.instr_valid), 32'h0);
        end
        bus.imem_ready = 1'b1;
        tick();
        check("stall response valid", 32'(bus.instr_valid), 32'h1);
        tick();
        check("seq count3", bus.retired_count, 32'd3);
        check("seq addr3", bus.imem_addr, 32'hC);
        $display("memory stall: released, retired=%0d", bus.retired_count);

        // Decode stall at 0xC
        bus.imem_rdata   = 32'h0123_4567;
        bus.decode_ready = 1'b0;
        tick();
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("dstall instr", bus.instr, 32'h0123_4567);
            check("dstall pc_plus4", bus.pc_plus4, 32'h10);
            check("dstall count", bus.retired_count, 32'd3);
            check("dstall imem_req", 32'(bus.imem_req), 32'h0);
        end
        bus.decode_ready = 1'b1;
        tick();
        bus.decode_ready = 1'b0;
        check("dstall next addr", bus.imem_addr, 32'h10);
        $display("decode stall: consumed, addr=%h", bus.imem_addr);

        // Branch / jump resolution
        fetch_consume(32'h1000_FFFF, 1'b1, 1'b0);
        check("branch imm -1", bus.imem_addr, 32'h10);
        fetch_consume(32'h1000_0004, 1'b1, 1'b0);
        check("branch imm +4", bus.imem_addr, 32'h24);
        fetch_consume(32'h0800_0004, 1'b0, 1'b1);
        check("jump back", bus.imem_addr, 32'h10);
        fetch_consume(32'h0800_0040, 1'b0, 1'b1);
        check("jump 0x40", bus.imem_addr, 32'h100);
        fetch_consume(32'h0800_0004, 1'b0, 1'b1);
        check("jump back 2", bus.imem_addr, 32'h10);
        fetch_consume(32'h0800_0040, 1'b1, 1'b1);
        check("jump over branch", bus.imem_addr, 32'h100);
        fetch_consume(32'h1000_FFFF, 1'b0, 1'b0);
        check("branch not taken", bus.imem_addr, 32'h104);
        check("count before reset", bus.retired_count, 32'd11);

        // Reset while fetching with a response present
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        reset          = 1'b1;
        tick();
        check("midreset fetch valid", 32'(bus.instr_valid), 32'h0);
        check("midreset fetch req", 32'(bus.imem_req), 32'h0);
        reset          = 1'b0;
        bus.imem_ready = 1'b0;
        #1;
        check("after fetch reset addr", bus.imem_addr, 32'h0);
        check("after fetch reset count", bus.retired_count, 32'd0);
        check("after fetch reset valid", 32'(bus.instr_valid), 32'h0);
        check("after fetch reset req", 32'(bus.imem_req), 32'h1);
        $display("reset in fetch: addr=%h retired=%0d", bus.imem_addr, bus.retired_count);

        // Retire a few, then reset while holding an instruction
        for (int i = 0; i < 5; i++) fetch_consume(32'h2008_0001, 1'b0, 1'b0);
        check("count five", bus.retired_count, 32'd5);
        check("addr five", bus.imem_addr, 32'h14);
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'h2008_0001;
        tick();
        check("hold before reset", 32'(bus.instr_valid), 32'h1);
        reset = 1'b1;
        tick();
        check("midreset valid", 32'(bus.instr_valid), 32'h0);
        check("midreset req", 32'(bus.imem_req), 32'h0);
        reset          = 1'b0;
        bus.imem_ready = 1'b0;
        #1;
        check("after valid reset addr", bus.imem_addr, 32'h0);
        check("after valid reset count", bus.retired_count, 32'd0);
        check("after valid reset instr", bus.instr, 32'h0);
        check("after valid reset valid", 32'(bus.instr_valid), 32'h0);
        $display("reset in valid: addr=%h retired=%0d", bus.imem_addr, bus.retired_count);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the main control decoder.
- Holds the PC and issues word requests to instruction memory over a req/ready handshake.
- Presents the fetched instruction and its opcode field (instr[31:26]) to the decoder and datapath.
- Computes the next PC from the branch/jump resolution returned by the datapath when each instruction is consumed.

Parameters:
- RESET_PC, 32'h00000000, PC loaded on reset; bits [1:0] are ignored and forced to 0.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  instruction memory read request.
- imem_addr  out  32  word-aligned fetch address.
- imem_ready  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  32  instruction word.
- instr  out  32  registered instruction for the decode stage.
- opcode  out  6  instr[31:26]; drives the control decoder.
- instr_valid  out  1  instr/opcode/pc_plus4 are valid.
- decode_ready  in  1  decode stage consumes the instruction this cycle.
- pc_plus4  out  32  address of instr + 4; also the link value for JAL.
- branch_taken  in  1  Branch AND ALU condition, resolved for the current instr.
- jump  in  1  Jump from the control decoder for the current instr.
- retired_count  out  32  number of instructions consumed.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (any state, including mid-fetch or while holding): pc <= RESET_PC & ~3, state <= FETCH, instr_valid <= 0, instr <= 0, retired_count <= 0.
- A memory response arriving in the reset cycle is discarded.
- Outputs during and after reset:
  - imem_req = 0 in the reset cycle.
  - imem_req = 1 from the first cycle after reset deasserts.
  - imem_addr = pc at all times; bits [1:0] are always 0.
- FSM has two states, FETCH and VALID.
- FETCH:
  - imem_req = 1, instr_valid = 0.
  - imem_addr and imem_req stay stable until imem_ready.
  - On imem_ready: instr <= imem_rdata, state <= VALID.
  - Without imem_ready: remain in FETCH indefinitely.
- VALID:
  - imem_req = 0, instr_valid = 1.
  - instr, opcode and pc_plus4 are held stable until consumed.
  - Consume event = instr_valid AND decode_ready.
  - On consume: pc <= next_pc, retired_count <= retired_count + 1 (wraps at 2^32), state <= FETCH.
  - branch_taken and jump are sampled only in the consume cycle and ignored otherwise.
  - Without consume: remain in VALID, pc and count unchanged.
- Next-PC selection, in priority order:
  - jump = 1: next_pc = {pc_plus4[31:28], instr[25:0], 2'b00}. Jump beats branch when both are asserted.
  - branch_taken = 1: next_pc = pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}), modulo 2^32 with no overflow detection.
  - Otherwise: next_pc = pc_plus4.
- pc_plus4 = pc + 4, modulo 2^32; pc = 32'hFFFFFFFC gives pc_plus4 = 0.
- Only one request is ever outstanding. Peak throughput is one instruction per 2 cycles: response cycle, then consume cycle.
- Latency: when imem_ready is asserted in the request cycle, instr_valid rises on the next clock edge.
- opcode is a pure slice of the registered instr, so it is glitch-free for the combinational decoder.

Test Plan:
- Reset: hold reset 2 cycles with imem_ready = 1 and rdata = 0xDEADBEEF -> during reset imem_req = 0 and instr_valid = 0; first cycle after release imem_req = 1, imem_addr = 0x00000000.
- Sequential fetch, imem_ready = 1 and decode_ready = 1 constantly, rdata = 0x20080001 -> imem_addr sequence 0x0, 0x4, 0x8 on alternating cycles; opcode = 6'b001000; retired_count = 3 after the third consume.
- Memory stall: hold imem_ready = 0 for 3 cycles at addr 0x8 -> imem_req = 1 and imem_addr = 0x8 stable throughout, instr_valid = 0; the response on cycle 4 asserts instr_valid next cycle.
- Decode stall: decode_ready = 0 for 2 cycles in VALID -> instr, pc_plus4 and retired_count unchanged, imem_req = 0; consume on cycle 3, then next fetch at pc + 4.
- Branch/jump, with instr at 0x10:
  - imm 0xFFFF, branch_taken = 1 -> next imem_addr = 0x10.
  - imm 0x0004, branch_taken = 1 -> 0x24.
  - J with instr[25:0] = 0x40 -> 0x100.
  - jump and branch_taken both 1 -> 0x100.
  - branch_taken = 1 while decode_ready = 0 -> ignored.
- Reset mid-operation: after 5 retired instructions, assert reset while in FETCH with imem_ready = 1 -> response dropped, pc = RESET_PC, retired_count = 0; repeat in VALID -> same.
